ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
// ID/EX pipeline register plus execute stage of the 5-stage MIPS core; consumes id_to_ex_bus, feeds MEM.
// Computes ALU result, drives data SRAM request, forwards its writeback to ID via ex_to_rf_bus.
// Owns HI/LO and a 32-iteration sequential divider (div/divu); requests a pipeline stall while dividing.
// PARAMETERS
// None; all widths come from `defines.vh` (`ID_TO_EX_WD`=159, `EX_TO_MEM_WD`=76, `WB_TO_RF_WD`=38, `StallBus`).
// PORTS
// clk              in   1     clock; all state updates on posedge
// rst              in   1     synchronous, active-high reset
// stall            in   StallBus  ctrl stall vector; bit2 = ID/EX reg, bit3 = EX/MEM reg
// id_to_ex_bus     in   159   {pc,inst,alu_op[11:0],sel_src1[2:0],sel_src2[3:0],ram_en,ram_wen[3:0],rf_we,rf_waddr,sel_rf_res,rdata1,rdata2}
// ex_to_mem_bus    out  76    {pc[75:44],ram_en[43],ram_wen[42:39],sel_rf_res[38],rf_we[37],rf_waddr[36:32],ex_result[31:0]}
// ex_to_rf_bus     out  38    forwarding {we,waddr[4:0],wdata[31:0]} to ID
// data_sram_en     out  1     data SRAM enable
// data_sram_wen    out  4     byte write enables
// data_sram_addr   out  32    rdata1 + sext(imm)
// data_sram_wdata  out  32    store data
// stallreq_for_ex  out  1     divider busy; ctrl holds stages <=2 and bubbles MEM
// BEHAVIOUR
// - ID/EX reg: rst -> all 0; stall[2]==Stop && stall[3]==NoStop -> load 0 (bubble); stall[2]==NoStop -> load bus; else hold.
// - Reset: all bus outputs 0, stallreq 0, HI=LO=0, divider FSM=IDLE; applies mid-divide (aborts, no HI/LO write).
// - src1: sel_src1[1]?pc : sel_src1[2]?{27'b0,sa} : rdata1. src2: [1]?sext(imm) : [2]?32'd8 : [3]?zext(imm) : rdata2.
// - alu_op one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}; add/sub mod 2^32, no overflow trap;
//   slt signed, sltu unsigned -> {31'b0,bit}; shifts: value=src2, amount=src1[4:0]; lui={src2[15:0],16'b0}; all-zero op -> 0.
// - ex_result: mfhi->HI, mflo->LO (decoded from inst funct 010000/010010), else ALU result. Purely combinational from ID/EX reg.
// - ex_to_rf_bus: we = rf_we & ~sel_rf_res (loads never forwarded from EX); waddr/wdata = rf_waddr/ex_result.
// - Store data: sb -> {4{rt[7:0]}}, sh -> {2{rt[15:0]}}, else rdata2; sram en/wen pass through from bus.
// - HI/LO writes only on a cycle where stall[3]==NoStop (instruction leaves EX): mult/multu -> {HI,LO}=64-bit product
//   (signed/unsigned); mthi/mtlo -> rdata1; div completion below. mfhi immediately after any of these sees the new value.
// - Divider FSM (div funct 011010 signed, divu 011011):
//   IDLE: div in EX -> latch |operands| (signed) or raw, cnt=0, ->RUN; stallreq=1 this cycle.
//   RUN: one restoring step per cycle, cnt++; stallreq=1; cnt==31 step -> DONE.
//   DONE: stallreq=0; edge leaving DONE writes LO=quotient, HI=remainder, ->IDLE.
//   Latency: 34 cycles in EX (1 IDLE + 32 RUN + 1 DONE). Never re-triggers on the same instruction.
//   Signed fixup: quotient negated if operand signs differ; remainder takes dividend sign.
//   Divide by zero: no trap; divu -> LO=32'hFFFF_FFFF, HI=dividend; div -> same raw result then sign fixup.
// - Bubble (all-zero inst = sll $0) produces no HI/LO write, no stallreq, rf_we 0.
// STRUCTURE
// - defines.vh: EX_TO_MEM_WD, bus field offsets, Stop/NoStop, div FSM state encodings (IDLE/RUN/DONE).
// - One sub-module: div_radix2 (operand latch, 32-step restoring shift/subtract, FSM, done pulse, sign fixup);
//   ALU, operand muxes, HI/LO and bus packing stay in ex_stage.
// TESTING
// - addiu $2,$1,-1 with rdata1=5 -> ex_result=4, ex_to_rf_bus={1,5'd2,32'd4} same cycle as ID/EX load.
// - div rs=-7, rt=2 -> stallreq high exactly 33 cycles then low 1; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; following mflo=-3.
// - divu rs=10, rt=0 -> LO=32'hFFFF_FFFF, HI=32'd10; rst asserted at RUN cycle 15 -> stallreq 0 next cycle, HI/LO=0.
// - multu 32'hFFFF_FFFF*2 -> HI=1, LO=32'hFFFF_FFFE; mult same operands -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE.
// - sb rt=32'h1234_56AB, base=32'h100, imm=3, wen=4'b1000 -> addr=32'h103, wdata=32'hABAB_ABAB, en=1.
// - stall[2]=Stop,stall[3]=NoStop -> next cycle bus outputs all 0; stall[2]=stall[3]=Stop -> outputs held, no HI/LO write.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, bus layouts, opcode/funct codes and divider state encoding
// for the execute stage of the 5-stage MIPS core.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int WB_TO_RF_WD  = 38;
    localparam int STALL_WD     = 6;

    // Stall vector bit owners: ID/EX register and EX/MEM register.
    localparam int   STALL_ID_EX  = 2;
    localparam int   STALL_EX_MEM = 3;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    // alu_op is one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ex_stage_div_radix2.sv
// 32-step restoring divider: latches |operands| on start, one shift/subtract
// per RUN cycle, holds the sign-fixed result in DONE until the instruction leaves EX.
module ex_stage_div_radix2
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        advance,
    output logic        busy,
    output div_state_e  state,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dsr;
    logic        neg_q;
    logic        neg_r;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign abs_a = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
    assign abs_b = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

    // Partial remainder stays below the divisor, so a non-negative trial fits in 32 bits
    // and bit 32 of the difference is a clean borrow flag.
    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            DIV_IDLE: begin
                busy = start;
                if (start) begin
                    state_nxt = DIV_RUN;
                end
            end
            DIV_RUN: begin
                busy = 1'b1;
                if (cnt == 5'd31) begin
                    state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (advance) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt   <= '0;
            quo   <= abs_a;
            rem   <= '0;
            dsr   <= abs_b;
            neg_q <= is_signed && (dividend[31] ^ divisor[31]);
            neg_r <= is_signed && dividend[31];
        end else if (state == DIV_RUN) begin
            cnt <= cnt + 5'd1;
            if (!trial[32]) begin
                rem <= trial[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= shifted[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign quotient  = neg_q ? (32'd0 - quo) : quo;
    assign remainder = neg_r ? (32'd0 - rem) : rem;

endmodule

// File: rtl/ex_stage.sv
// ID/EX pipeline register plus execute stage: ALU, data SRAM request, EX->ID
// forwarding, HI/LO registers and the sequential divider with its stall request.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [WB_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    id_ex_t      idex;
    ex_mem_t     mem_out;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_special;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    logic        leave;
    logic        div_in_ex;
    logic        div_consumed;
    logic        div_fin;
    div_state_e  div_state;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        unused_bits;

    // Stall handshake: stallreq_for_ex asks ctrl to hold ID/EX and EX/MEM; the
    // instruction in EX is retired (HI/LO updates allowed) only when stall[3] is NoStop.
    assign leave = (stall[STALL_EX_MEM] == NO_STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            idex <= '0;
        end else if (stall[STALL_ID_EX] == STOP && stall[STALL_EX_MEM] == NO_STOP) begin
            idex <= '0;
        end else if (stall[STALL_ID_EX] == NO_STOP) begin
            idex <= id_to_ex_bus;
        end
    end

    assign opcode     = idex.inst[31:26];
    assign funct      = idex.inst[5:0];
    assign is_special = (opcode == OP_SPECIAL);
    assign imm_sext   = sext16(idex.inst[15:0]);
    assign imm_zext   = {16'b0, idex.inst[15:0]};

    always_comb begin
        src1 = idex.rdata1;
        if (idex.sel_src1[1]) begin
            src1 = idex.pc;
        end else if (idex.sel_src1[2]) begin
            src1 = {27'b0, idex.inst[10:6]};
        end
    end

    always_comb begin
        src2 = idex.rdata2;
        if (idex.sel_src2[1]) begin
            src2 = imm_sext;
        end else if (idex.sel_src2[2]) begin
            src2 = 32'd8;
        end else if (idex.sel_src2[3]) begin
            src2 = imm_zext;
        end
    end

    always_comb begin
        alu_res = '0;
        if (idex.alu_op[ALU_ADD]) begin
            alu_res = src1 + src2;
        end else if (idex.alu_op[ALU_SUB]) begin
            alu_res = src1 - src2;
        end else if (idex.alu_op[ALU_SLT]) begin
            alu_res = {31'b0, $signed(src1) < $signed(src2)};
        end else if (idex.alu_op[ALU_SLTU]) begin
            alu_res = {31'b0, src1 < src2};
        end else if (idex.alu_op[ALU_AND]) begin
            alu_res = src1 & src2;
        end else if (idex.alu_op[ALU_NOR]) begin
            alu_res = ~(src1 | src2);
        end else if (idex.alu_op[ALU_OR]) begin
            alu_res = src1 | src2;
        end else if (idex.alu_op[ALU_XOR]) begin
            alu_res = src1 ^ src2;
        end else if (idex.alu_op[ALU_SLL]) begin
            alu_res = src2 << src1[4:0];
        end else if (idex.alu_op[ALU_SRL]) begin
            alu_res = src2 >> src1[4:0];
        end else if (idex.alu_op[ALU_SRA]) begin
            alu_res = $signed(src2) >>> src1[4:0];
        end else if (idex.alu_op[ALU_LUI]) begin
            alu_res = {src2[15:0], 16'b0};
        end
    end

    always_comb begin
        ex_result = alu_res;
        if (is_special && funct == FN_MFHI) begin
            ex_result = hi;
        end else if (is_special && funct == FN_MFLO) begin
            ex_result = lo;
        end
    end

    assign prod_s = {{32{idex.rdata1[31]}}, idex.rdata1} * {{32{idex.rdata2[31]}}, idex.rdata2};
    assign prod_u = {32'b0, idex.rdata1} * {32'b0, idex.rdata2};

    assign div_in_ex = is_special && (funct == FN_DIV || funct == FN_DIVU);
    assign div_fin   = (div_state == DIV_DONE) && leave;

    // A div held in ID/EX after its result was written must not start a second divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_consumed <= 1'b0;
        end else if (stall[STALL_ID_EX] == NO_STOP || stall[STALL_EX_MEM] == NO_STOP) begin
            div_consumed <= 1'b0;
        end else if (div_fin) begin
            div_consumed <= 1'b1;
        end
    end

    ex_stage_div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_in_ex && !div_consumed),
        .is_signed (funct == FN_DIV),
        .dividend  (idex.rdata1),
        .divisor   (idex.rdata2),
        .advance   (leave),
        .busy      (stallreq_for_ex),
        .state     (div_state),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_fin) begin
            hi <= div_r;
            lo <= div_q;
        end else if (leave && is_special) begin
            if (funct == FN_MULT) begin
                {hi, lo} <= prod_s;
            end else if (funct == FN_MULTU) begin
                {hi, lo} <= prod_u;
            end else if (funct == FN_MTHI) begin
                hi <= idex.rdata1;
            end else if (funct == FN_MTLO) begin
                lo <= idex.rdata1;
            end
        end
    end

    always_comb begin
        data_sram_wdata = idex.rdata2;
        if (opcode == OP_SB) begin
            data_sram_wdata = {4{idex.rdata2[7:0]}};
        end else if (opcode == OP_SH) begin
            data_sram_wdata = {2{idex.rdata2[15:0]}};
        end
    end

    assign data_sram_en   = idex.ram_en;
    assign data_sram_wen  = idex.ram_wen;
    assign data_sram_addr = idex.rdata1 + imm_sext;

    assign mem_out.pc         = idex.pc;
    assign mem_out.ram_en     = idex.ram_en;
    assign mem_out.ram_wen    = idex.ram_wen;
    assign mem_out.sel_rf_res = idex.sel_rf_res;
    assign mem_out.rf_we      = idex.rf_we;
    assign mem_out.rf_waddr   = idex.rf_waddr;
    assign mem_out.ex_result  = ex_result;
    assign ex_to_mem_bus      = mem_out;

    // Load results are not available in EX, so they are never forwarded from here.
    assign ex_to_rf_bus = {idex.rf_we & ~idex.sel_rf_res, idex.rf_waddr, ex_result};

    assign unused_bits = ^{stall[5:4], stall[1:0], idex.inst[25:16],
                           idex.sel_src1[0], idex.sel_src2[0]};

endmodule
